// File: rtl/sub_16_bit_pipe.sv
// Two-stage pipelined subtractor D = A - B - B_in with valid/ready handshake.
// Define SUB_OVF_EN to register a signed-overflow flag on V; otherwise V is tied to 0.
module sub_16_bit_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HALF = WIDTH / 2;

  logic            s1_valid_q;
  logic [HALF-1:0] lo_q;
  logic            b1_q;
  logic [HALF-1:0] a_hi_q;
  logic [HALF-1:0] b_hi_q;

  logic [WIDTH-1:0] d_q;
  logic             b_out_q;
  logic             out_valid_q;

  logic            s2_load;
  logic            in_fire;
  logic [HALF:0]   lo_diff;
  logic [HALF:0]   hi_diff;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  // Extra top bit of each difference is the borrow out of that half.
  assign lo_diff = {1'b0, A[HALF-1:0]} - {1'b0, B[HALF-1:0]} - {{HALF{1'b0}}, B_in};
  assign hi_diff = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{HALF{1'b0}}, b1_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      lo_q       <= '0;
      b1_q       <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      lo_q       <= lo_diff[HALF-1:0];
      b1_q       <= lo_diff[HALF];
      a_hi_q     <= A[WIDTH-1:HALF];
      b_hi_q     <= B[WIDTH-1:HALF];
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Result registers only move on a stage-2 load, so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      b_out_q     <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        d_q     <= {hi_diff[HALF-1:0], lo_q};
        b_out_q <= hi_diff[HALF];
      end
    end
  end

`ifdef SUB_OVF_EN
  logic v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (s2_load && s1_valid_q) begin
      v_q <= (a_hi_q[HALF-1] != b_hi_q[HALF-1]) && (hi_diff[HALF-1] != a_hi_q[HALF-1]);
    end
  end

  assign V = v_q;
`else
  assign V = 1'b0;
`endif

  assign D         = d_q;
  assign B_out     = b_out_q;
  assign out_valid = out_valid_q;

endmodule
